// File: rtl/spi_inst_ctrl.sv
// Purpose : turns SPI-slave frame pulses and bytes into register reads and writes, status byte, and sticky error flags.
// Latency : write strobe 1 cycle after data frame_end; read data on tx 2 cycles after command frame_end.
// Backpressure: none; the master must leave at least 3 clk cycles between command and data frames for reads.
//
// Ports:
//   i_clk, i_rst_n (synchronous, active-high despite the name)
//   i_frame_begin / i_frame_end : chip-select assert/deassert pulses from the slave
//   i_rx_data  : received byte, valid with i_frame_end
//   o_tx_data  : byte the slave loads on i_frame_begin
//   o_reg_addr / i_reg_rdata / o_reg_wr_en / o_reg_wdata : register bank port
//   i_clr_err  : clears sticky flags; o_busy, o_cmd_err, o_to_err : status
`timescale 1ns/1ps
module spi_inst_ctrl #(
  parameter int          ADDR_W    = 4,
  parameter int          TIMEOUT   = 1000,
  parameter logic [4:0]  STATUS_ID = 5'b10100
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_frame_begin,
  input  logic              i_frame_end,
  input  logic [7:0]        i_rx_data,
  output logic [7:0]        o_tx_data,
  output logic [ADDR_W-1:0] o_reg_addr,
  input  logic [7:0]        i_reg_rdata,
  output logic              o_reg_wr_en,
  output logic [7:0]        o_reg_wdata,
  input  logic              i_clr_err,
  output logic              o_busy,
  output logic              o_cmd_err,
  output logic              o_to_err
);

  localparam int               CNT_W    = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CMD,
    S_WAIT_DATA,
    S_DATA
  } state_t;

  state_t              r_state;
  logic [7:0]          r_tx_data;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_is_read;
  logic                r_wr_en;
  logic [7:0]          r_wdata;
  logic                r_busy;
  logic                r_cmd_err;
  logic                r_to_err;
  logic [CNT_W-1:0]    r_cnt;

  state_t              w_state_mid;
  state_t              w_state_nxt;
  logic                w_set_cmd_err;
  logic                w_set_to_err;
  logic                w_latch_cmd;
  logic                w_wr_fire;
  logic                w_rsvd_bad;
  logic                w_cmd_err_nxt;
  logic                w_to_err_nxt;
  logic [7:0]          w_status_nxt;
  logic                w_read_hold;

  // Bits between the direction bit and the address must be zero.
  assign w_rsvd_bad = |(i_rx_data[6:0] >> ADDR_W);

  // frame_end is resolved first (w_state_mid), then frame_begin is applied
  // to that intermediate state, so a coincident pair behaves as end-then-begin.
  always_comb begin
    w_state_mid   = r_state;
    w_state_nxt   = r_state;
    w_set_cmd_err = 1'b0;
    w_set_to_err  = 1'b0;
    w_latch_cmd   = 1'b0;
    w_wr_fire     = 1'b0;

    if (i_frame_end) begin
      case (r_state)
        S_CMD: begin
          if (w_rsvd_bad) begin
            w_set_cmd_err = 1'b1;
            w_state_mid   = S_IDLE;
          end else begin
            w_latch_cmd = 1'b1;
            w_state_mid = S_WAIT_DATA;
          end
        end
        S_WAIT_DATA: begin
          w_set_cmd_err = 1'b1;
          w_state_mid   = S_IDLE;
        end
        S_DATA: begin
          w_wr_fire   = ~r_is_read;
          w_state_mid = S_IDLE;
        end
        default: ;
      endcase
    end

    w_state_nxt = w_state_mid;
    if (i_frame_begin) begin
      case (w_state_mid)
        S_IDLE:      w_state_nxt = S_CMD;
        S_CMD:       w_set_cmd_err = 1'b1;   // restart: the new frame is a command
        S_WAIT_DATA: w_state_nxt = S_DATA;
        S_DATA: begin
          w_set_cmd_err = 1'b1;
          w_state_nxt   = S_CMD;
        end
        default: ;
      endcase
    end else if (r_state == S_WAIT_DATA && w_state_mid == S_WAIT_DATA &&
                 r_cnt == CNT_LAST) begin
      w_set_to_err = 1'b1;
      w_state_nxt  = S_IDLE;
    end
  end

  // Set beats clear when both happen in the same cycle.
  assign w_cmd_err_nxt = w_set_cmd_err | (r_cmd_err & ~i_clr_err);
  assign w_to_err_nxt  = w_set_to_err  | (r_to_err  & ~i_clr_err);
  assign w_status_nxt  = {STATUS_ID, w_cmd_err_nxt, w_to_err_nxt, 1'b0};

  // Read data, once captured, stays on tx until the data frame is over.
  assign w_read_hold = r_is_read &&
                       (r_state == S_WAIT_DATA || r_state == S_DATA) &&
                       (w_state_nxt == S_WAIT_DATA || w_state_nxt == S_DATA);

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      r_state   <= S_IDLE;
      r_tx_data <= {STATUS_ID, 3'b000};
      r_addr    <= '0;
      r_is_read <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wdata   <= 8'h00;
      r_busy    <= 1'b0;
      r_cmd_err <= 1'b0;
      r_to_err  <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_cmd_err <= w_cmd_err_nxt;
      r_to_err  <= w_to_err_nxt;
      r_wr_en   <= w_wr_fire;

      if (w_latch_cmd) begin
        r_addr    <= i_rx_data[ADDR_W-1:0];
        r_is_read <= i_rx_data[7];
      end

      if (w_wr_fire) begin
        r_wdata <= i_rx_data;
      end

      // Counter runs only while staying in WAIT_DATA; any entry starts it at 0.
      if (r_state == S_WAIT_DATA && w_state_nxt == S_WAIT_DATA) begin
        if (r_cnt != CNT_LAST) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end

      // First WAIT_DATA cycle of a read: reg_addr has settled, capture rdata.
      if (r_state == S_WAIT_DATA && r_is_read && r_cnt == '0 &&
          (w_state_nxt == S_WAIT_DATA || w_state_nxt == S_DATA)) begin
        r_tx_data <= i_reg_rdata;
      end else if (!w_read_hold) begin
        r_tx_data <= w_status_nxt;
      end
    end
  end

  assign o_tx_data   = r_tx_data;
  assign o_reg_addr  = r_addr;
  assign o_reg_wr_en = r_wr_en;
  assign o_reg_wdata = r_wdata;
  assign o_busy      = r_busy;
  assign o_cmd_err   = r_cmd_err;
  assign o_to_err    = r_to_err;

endmodule
